// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared ray/triangle types, Q16.16 constants and scheduler states
package rt_pkg;

   typedef logic [0:2][31:0] vec3_t;
   typedef vec3_t [0:2]      triangle_t;
   typedef vec3_t [0:1]      ray_t;

   localparam logic signed [31:0] FIP_ONE = 32'sh00010000;
   localparam logic signed [31:0] T_MAX   = 32'sh7FFFFFFF;

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

   // Distances are signed Q16.16, so the nearest hit is the signed minimum.
   function automatic logic t_closer(input logic [31:0] cand, input logic [31:0] best);
      return $signed(cand) < $signed(best);
   endfunction

endpackage

// File: rtl/closest_hit_tracker.sv
// rtl/closest_hit_tracker.sv - clear/update register holding the nearest valid hit of a ray job
module closest_hit_tracker
   import rt_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_clear,
   input  logic             i_update,
   input  logic [CNT_W-1:0] i_idx,
   input  logic             i_hit,
   input  logic             i_invalid,
   input  logic [31:0]      i_t,
   input  logic [0:2][31:0] i_normal,
   output logic             o_hit,
   output logic [CNT_W-1:0] o_idx,
   output logic [31:0]      o_t,
   output logic [0:2][31:0] o_normal
);

   logic             hit_q, hit_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [31:0]      t_q, t_d;
   vec3_t            normal_q, normal_d;

   // Strict less-than keeps the earlier index on ties and never accepts T_MAX.
   always_comb begin
      hit_d    = hit_q;
      idx_d    = idx_q;
      t_d      = t_q;
      normal_d = normal_q;
      if (i_clear) begin
         hit_d    = 1'b0;
         idx_d    = '0;
         t_d      = T_MAX;
         normal_d = '0;
      end else if (i_update && i_hit && !i_invalid && t_closer(i_t, t_q)) begin
         hit_d    = 1'b1;
         idx_d    = i_idx;
         t_d      = i_t;
         normal_d = i_normal;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         hit_q    <= 1'b0;
         idx_q    <= '0;
         t_q      <= T_MAX;
         normal_q <= '0;
      end else begin
         hit_q    <= hit_d;
         idx_q    <= idx_d;
         t_q      <= t_d;
         normal_q <= normal_d;
      end
   end

   assign o_hit    = hit_q;
   assign o_idx    = idx_q;
   assign o_t      = t_q;
   assign o_normal = normal_q;

endmodule

// File: rtl/isect_scheduler.sv
// rtl/isect_scheduler.sv - per-ray closest-hit sequencer over a triangle list
// Optional ISECT_STATS_EN adds o_tested_cnt / o_invalid_cnt job counters.
module isect_scheduler
   import rt_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int CNT_W     = 16,
   parameter int ISECT_LAT = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_start,
   input  logic [0:1][0:2][31:0] i_ray,
   input  logic [ADDR_W-1:0]     i_base_addr,
   input  logic [CNT_W-1:0]      i_tri_count,
   output logic                  o_busy,
   output logic                  o_mem_req,
   output logic [ADDR_W-1:0]     o_mem_addr,
   input  logic                  i_mem_ack,
   input  logic [0:2][0:2][31:0] i_mem_data,
   output logic [0:2][0:2][31:0] o_isect_tri,
   output logic [0:1][0:2][31:0] o_isect_ray,
   input  logic                  i_isect_hit,
   input  logic [31:0]           i_isect_t,
   input  logic [0:2][31:0]      i_isect_normal,
   input  logic                  i_isect_invalid,
   output logic                  o_valid,
   input  logic                  i_ready,
`ifdef ISECT_STATS_EN
   output logic [CNT_W-1:0]      o_tested_cnt,
   output logic [CNT_W-1:0]      o_invalid_cnt,
`endif
   output logic                  o_hit,
   output logic [CNT_W-1:0]      o_tri_idx,
   output logic [31:0]           o_t,
   output logic [0:2][31:0]      o_normal
);

   localparam int               LAT_W    = $clog2(ISECT_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ISECT_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   triangle_t         tri_q, tri_d;
   ray_t              ray_q, ray_d;
   logic              trk_clear;
   logic              trk_update;
   logic              last_tri;

   assign last_tri = (idx_q == count_q - CNT_ONE);

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      idx_d      = idx_q;
      lat_d      = lat_q;
      tri_d      = tri_q;
      ray_d      = ray_q;
      trk_clear  = 1'b0;
      trk_update = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               ray_d     = i_ray;
               base_d    = i_base_addr;
               count_d   = i_tri_count;
               idx_d     = '0;
               trk_clear = 1'b1;
               state_d   = (i_tri_count == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (i_mem_ack) begin
               tri_d   = i_mem_data;
               lat_d   = LAT_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // Counter sits at zero for one extra cycle: that cycle samples the datapath.
            if (lat_q == '0) begin
               trk_update = 1'b1;
               if (last_tri) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + CNT_ONE;
                  state_d = FETCH;
               end
            end else begin
               lat_d = lat_q - LAT_ONE;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         lat_q   <= '0;
         tri_q   <= '0;
         ray_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         tri_q   <= tri_d;
         ray_q   <= ray_d;
      end
   end

   assign o_busy      = (state_q != IDLE);
   assign o_mem_req   = (state_q == FETCH);
   assign o_valid     = (state_q == DONE);
   assign o_mem_addr  = base_q + ADDR_W'(idx_q);
   assign o_isect_tri = tri_q;
   assign o_isect_ray = ray_q;

   closest_hit_tracker #(
      .CNT_W (CNT_W)
   ) u_tracker (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clear   (trk_clear),
      .i_update  (trk_update),
      .i_idx     (idx_q),
      .i_hit     (i_isect_hit),
      .i_invalid (i_isect_invalid),
      .i_t       (i_isect_t),
      .i_normal  (i_isect_normal),
      .o_hit     (o_hit),
      .o_idx     (o_tri_idx),
      .o_t       (o_t),
      .o_normal  (o_normal)
   );

`ifdef ISECT_STATS_EN
   logic [CNT_W-1:0] tested_q, tested_d;
   logic [CNT_W-1:0] invalid_q, invalid_d;

   always_comb begin
      tested_d  = tested_q;
      invalid_d = invalid_q;
      if (trk_clear) begin
         tested_d  = '0;
         invalid_d = '0;
      end else if (trk_update) begin
         tested_d = tested_q + CNT_ONE;
         if (i_isect_invalid) begin
            invalid_d = invalid_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         tested_q  <= '0;
         invalid_q <= '0;
      end else begin
         tested_q  <= tested_d;
         invalid_q <= invalid_d;
      end
   end

   assign o_tested_cnt  = tested_q;
   assign o_invalid_cnt = invalid_q;
`endif

endmodule

// File: tb/tb_isect_scheduler.sv
// tb/tb_isect_scheduler.sv - randomized and directed bench for isect_scheduler with a behavioural job model
module tb_isect_scheduler;

   localparam int          ADDR_W = 16;
   localparam int          CNT_W  = 16;
   localparam int          LAT    = 1;
   localparam logic [31:0] TMAX   = 32'h7FFFFFFF;

   logic                  i_clk = 1'b0;
   logic                  i_rstn;
   logic                  i_start;
   logic [0:1][0:2][31:0] i_ray;
   logic [ADDR_W-1:0]     i_base_addr;
   logic [CNT_W-1:0]      i_tri_count;
   logic                  o_busy;
   logic                  o_mem_req;
   logic [ADDR_W-1:0]     o_mem_addr;
   logic                  i_mem_ack;
   logic [0:2][0:2][31:0] i_mem_data;
   logic [0:2][0:2][31:0] o_isect_tri;
   logic [0:1][0:2][31:0] o_isect_ray;
   logic                  i_isect_hit;
   logic [31:0]           i_isect_t;
   logic [0:2][31:0]      i_isect_normal;
   logic                  i_isect_invalid;
   logic                  o_valid;
   logic                  i_ready;
   logic                  o_hit;
   logic [CNT_W-1:0]      o_tri_idx;
   logic [31:0]           o_t;
   logic [0:2][31:0]      o_normal;
`ifdef ISECT_STATS_EN
   logic [CNT_W-1:0]      o_tested_cnt;
   logic [CNT_W-1:0]      o_invalid_cnt;
`endif

   always #5 i_clk = ~i_clk;

   isect_scheduler #(
      .ADDR_W    (ADDR_W),
      .CNT_W     (CNT_W),
      .ISECT_LAT (LAT)
   ) dut (
      .i_clk           (i_clk),
      .i_rstn          (i_rstn),
      .i_start         (i_start),
      .i_ray           (i_ray),
      .i_base_addr     (i_base_addr),
      .i_tri_count     (i_tri_count),
      .o_busy          (o_busy),
      .o_mem_req       (o_mem_req),
      .o_mem_addr      (o_mem_addr),
      .i_mem_ack       (i_mem_ack),
      .i_mem_data      (i_mem_data),
      .o_isect_tri     (o_isect_tri),
      .o_isect_ray     (o_isect_ray),
      .i_isect_hit     (i_isect_hit),
      .i_isect_t       (i_isect_t),
      .i_isect_normal  (i_isect_normal),
      .i_isect_invalid (i_isect_invalid),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
`ifdef ISECT_STATS_EN
      .o_tested_cnt    (o_tested_cnt),
      .o_invalid_cnt   (o_invalid_cnt),
`endif
      .o_hit           (o_hit),
      .o_tri_idx       (o_tri_idx),
      .o_t             (o_t),
      .o_normal        (o_normal)
   );

   // Datapath stand-in: result fields are encoded in the triangle, delayed LAT cycles.
   logic [0:2][0:2][31:0] dp [LAT];
   always @(posedge i_clk) begin
      dp[0] <= o_isect_tri;
      for (int s = 1; s < LAT; s++) dp[s] <= dp[s-1];
   end
   assign i_isect_t       = dp[LAT-1][0][0];
   assign i_isect_hit     = dp[LAT-1][0][1][0];
   assign i_isect_invalid = dp[LAT-1][0][1][1];
   assign i_isect_normal  = dp[LAT-1][1];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Job description
   logic [31:0]  jt [16];
   bit           jh [16];
   bit           ji [16];
   logic [95:0]  jn [16];
   int           jd [16];
   logic [287:0] jw [16];

   // Expected per-cycle view, maintained by the driver, checked by the compare process
   bit           chk_en = 1'b0;
   bit           exp_busy, exp_req, exp_valid, exp_tri_chk;
   logic [15:0]  exp_addr;
   logic [191:0] exp_ray;
   logic [287:0] exp_tri;
   bit           exp_hit;
   logic [15:0]  exp_idx;
   logic [31:0]  exp_t;
   logic [95:0]  exp_normal;
   int           exp_tested, exp_inv;

   logic [15:0]  cap_idx;
   logic [31:0]  cap_t;
   logic         cap_hit;
`ifdef ISECT_STATS_EN
   logic [15:0]  cap_tested, cap_inv;
`endif

   always @(negedge i_clk) begin
      if (chk_en && i_rstn) begin
         chk("busy", o_busy, exp_busy);
         chk("mem_req", o_mem_req, exp_req);
         if (exp_req) chk("mem_addr", o_mem_addr, exp_addr);
         if (exp_busy) chk("isect_ray", o_isect_ray, exp_ray);
         if (exp_tri_chk) chk("isect_tri", o_isect_tri, exp_tri);
         chk("valid", o_valid, exp_valid);
         if (exp_valid) begin
            chk("hit", o_hit, exp_hit);
            chk("t", o_t, exp_t);
            if (exp_hit) begin
               chk("tri_idx", o_tri_idx, exp_idx);
               chk("normal", o_normal, exp_normal);
            end
`ifdef ISECT_STATS_EN
            chk("tested_cnt", o_tested_cnt, 16'(exp_tested));
            chk("invalid_cnt", o_invalid_cnt, 16'(exp_inv));
`endif
         end
      end
   end

   function automatic logic [287:0] rnd288();
      return {$urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [191:0] rnd192();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic build_tris(input int n);
      logic [0:2][0:2][31:0] tr;
      for (int i = 0; i < n; i++) begin
         tr       = rnd288();
         tr[0][0] = jt[i];
         tr[0][1] = {30'($urandom), ji[i], jh[i]};
         tr[1]    = jn[i];
         jw[i]    = tr;
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Nearest candidate: hit, not invalid, finite t; ties go to the lowest index.
   task automatic model(input int n);
      exp_hit = 0; exp_idx = 0; exp_t = TMAX; exp_normal = 0; exp_inv = 0;
      exp_tested = n;
      for (int i = 0; i < n; i++) begin
         if (ji[i]) exp_inv++;
         if (jh[i] && !ji[i] && jt[i] != TMAX) begin
            if (!exp_hit || $signed(jt[i]) < $signed(exp_t)) begin
               exp_hit = 1; exp_idx = 16'(i); exp_t = jt[i]; exp_normal = jn[i];
            end
         end
      end
   endtask

   task automatic run_job(input logic [15:0] base, input int n, input int rdy_low, input bit pulse);
      logic [191:0] r;
      build_tris(n);
      model(n);
      r = rnd192();
      i_ray = r; exp_ray = r;
      i_base_addr = base; i_tri_count = 16'(n); i_start = 1;
      exp_busy = 0; exp_req = 0; exp_valid = 0; exp_tri_chk = 0;
      i_mem_ack = 1'($urandom); i_mem_data = rnd288();
      tick();
      i_start = 0; i_ray = rnd192(); i_base_addr = 16'($urandom); i_tri_count = 16'($urandom);
      exp_busy = 1;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k <= jd[i]; k++) begin
            exp_req = 1; exp_addr = base + 16'(i); exp_tri_chk = 0;
            i_mem_ack = (k == jd[i]);
            i_mem_data = (k == jd[i]) ? jw[i] : rnd288();
            tick();
         end
         for (int k = 0; k <= LAT; k++) begin
            exp_req = 0; exp_tri_chk = 1; exp_tri = jw[i];
            i_mem_ack = 1'($urandom); i_mem_data = rnd288();
            tick();
         end
      end
      exp_req = 0; exp_tri_chk = 0; exp_valid = 1;
      cap_hit = o_hit; cap_idx = o_tri_idx; cap_t = o_t;
`ifdef ISECT_STATS_EN
      cap_tested = o_tested_cnt; cap_inv = o_invalid_cnt;
`endif
      for (int k = 0; k < rdy_low; k++) begin
         i_ready = 0; i_start = pulse ? 1'($urandom) : 1'b0; i_mem_ack = 1'($urandom);
         tick();
      end
      i_ready = 1; i_start = pulse ? 1'($urandom) : 1'b0;
      tick();
      i_ready = 0; i_start = 0; i_mem_ack = 0;
      exp_busy = 0; exp_valid = 0;
   endtask

   task automatic fill_default(input int n);
      for (int i = 0; i < n; i++) begin
         jh[i] = 1; ji[i] = 0; jd[i] = 0;
         jn[i] = {$urandom, $urandom, $urandom};
      end
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         case ($urandom % 4)
            0:       jt[i] = $urandom;
            1:       jt[i] = 32'($urandom_range(0, 6)) << 16;
            2:       jt[i] = TMAX;
            default: jt[i] = -(32'($urandom_range(1, 4)) << 16);
         endcase
         jh[i] = ($urandom % 4) != 0;
         ji[i] = ($urandom % 5) == 0;
         jn[i] = {$urandom, $urandom, $urandom};
         jd[i] = $urandom % 4;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      i_rstn = 0; i_start = 0; i_ray = '0; i_base_addr = '0; i_tri_count = '0;
      i_mem_ack = 0; i_mem_data = '0; i_ready = 0;
      exp_busy = 0; exp_req = 0; exp_valid = 0; exp_tri_chk = 0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_mem_req", o_mem_req, 1'b0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_hit", o_hit, 1'b0);
      chk("rst_tri_idx", o_tri_idx, 16'h0);
      chk("rst_t", o_t, TMAX);
      chk("rst_normal", o_normal, 96'h0);
      chk("rst_isect_tri", o_isect_tri, 288'h0);
      chk("rst_isect_ray", o_isect_ray, 192'h0);
      i_rstn = 1; chk_en = 1;
      tick();

      // nearest of three hits
      fill_default(3);
      jt[0] = 32'h30000; jt[1] = 32'h10000; jt[2] = 32'h20000;
      run_job(16'h0100, 3, 0, 0);
      chk("plan1_hit", cap_hit, 1'b1);
      chk("plan1_idx", cap_idx, 16'd1);
      chk("plan1_t", cap_t, 32'h10000);

      // invalid closer hit is rejected
      fill_default(2);
      jt[0] = 32'h20000; ji[0] = 1; jt[1] = 32'h50000;
      run_job(16'h0400, 2, 1, 0);
      chk("plan2_idx", cap_idx, 16'd1);
      chk("plan2_t", cap_t, 32'h50000);
`ifdef ISECT_STATS_EN
      chk("plan2_tested", cap_tested, 16'd2);
      chk("plan2_invalid", cap_inv, 16'd1);
`endif

      // empty list
      run_job(16'h0800, 0, 0, 0);
      chk("plan3_hit", cap_hit, 1'b0);
      chk("plan3_t", cap_t, TMAX);

      // ties keep the lower index, slow memory
      fill_default(3);
      jt[0] = 32'h18000; jt[1] = 32'h01000; jh[1] = 0; jt[2] = 32'h18000;
      jd[0] = 5; jd[1] = 5; jd[2] = 5;
      run_job(16'h1234, 3, 0, 0);
      chk("plan4_idx", cap_idx, 16'd0);
      chk("plan4_t", cap_t, 32'h18000);

      // consumer stall with ignored start pulses
      fill_default(1);
      jt[0] = 32'h7000;
      run_job(16'h2000, 1, 10, 1);
      chk("plan5_t", cap_t, 32'h7000);

      // hit at T_MAX only, then address wrap
      fill_default(1);
      jt[0] = TMAX;
      run_job(16'h3000, 1, 0, 0);
      chk("tmax_hit", cap_hit, 1'b0);
      fill_random(4);
      run_job(16'hFFFE, 4, 2, 1);

      // reset mid-fetch
      fill_default(2);
      jt[0] = 32'h10000; jt[1] = 32'h20000; jd[0] = 5;
      exp_ray = rnd192(); i_ray = exp_ray;
      i_base_addr = 16'h0200; i_tri_count = 16'd2; i_start = 1;
      tick();
      i_start = 0; exp_busy = 1; exp_req = 1; exp_addr = 16'h0200; i_mem_ack = 0;
      tick();
      #2 i_rstn = 0;
      #1;
      chk("mid_rst_busy", o_busy, 1'b0);
      chk("mid_rst_mem_req", o_mem_req, 1'b0);
      chk("mid_rst_valid", o_valid, 1'b0);
      chk("mid_rst_t", o_t, TMAX);
      chk("mid_rst_isect_tri", o_isect_tri, 288'h0);
      chk("mid_rst_isect_ray", o_isect_ray, 192'h0);
      exp_busy = 0; exp_req = 0; exp_valid = 0;
      tick();
      tick();
      i_rstn = 1;
      tick();
      fill_default(3);
      jt[0] = 32'h30000; jt[1] = 32'h10000; jt[2] = 32'h20000;
      run_job(16'h0100, 3, 0, 0);
      chk("post_rst_idx", cap_idx, 16'd1);
      chk("post_rst_t", cap_t, 32'h10000);

      for (int j = 0; j < 30; j++) begin
         int n;
         n = $urandom_range(0, 6);
         fill_random(n);
         run_job(16'($urandom), n, $urandom_range(0, 4), 1'($urandom));
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
